// File: rtl/four_bit_adder_pkg.sv
// Shared width constant and data types for the registered 4-bit adder.
// Optional overflow flag is enabled by defining FOURBIT_ADDER_OVF_EN.
package four_bit_adder_pkg;

    localparam int ADDER_W = 4;

    typedef logic [ADDER_W-1:0] nibble_t;
    typedef logic [ADDER_W:0]   sum5_t;

endpackage

// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for four_bit_adder; Ovf exists only with FOURBIT_ADDER_OVF_EN.
interface four_bit_adder_if;
    import four_bit_adder_pkg::*;

    nibble_t A;
    nibble_t B;
    logic    Cin;
    nibble_t S;
    logic    Cout;
`ifdef FOURBIT_ADDER_OVF_EN
    logic    Ovf;
`endif

`ifdef FOURBIT_ADDER_OVF_EN
    modport master (output A, output B, output Cin, input S, input Cout, input Ovf);
    modport slave  (input A, input B, input Cin, output S, output Cout, output Ovf);
`else
    modport master (output A, output B, output Cin, input S, input Cout);
    modport slave  (input A, input B, input Cin, output S, output Cout);
`endif

endinterface

// File: rtl/four_bit_adder_full_adder.sv
// Single-bit combinational full-adder cell used to build the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder: {Cout, S} <= A + B + Cin each clock.
// Define FOURBIT_ADDER_OVF_EN to add the registered two's-complement overflow flag.
module four_bit_adder
    import four_bit_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    four_bit_adder_if.slave  bus
);

    logic [ADDER_W:0] carry;
    nibble_t          sum_bits;
    sum5_t            sum_d;
    sum5_t            sum_q;

    assign carry[0] = bus.Cin;

    for (genvar i = 0; i < ADDER_W; i++) begin : g_fa
        full_adder u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    assign sum_d = {carry[ADDER_W], sum_bits};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.S    = sum_q[ADDER_W-1:0];
    assign bus.Cout = sum_q[ADDER_W];

`ifdef FOURBIT_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into and out of the sign bit differ exactly on signed overflow.
    assign ovf_d = carry[ADDER_W-1] ^ carry[ADDER_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed and exhaustive self-checking bench for four_bit_adder.
module tb_four_bit_adder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    four_bit_adder_if bus ();

    four_bit_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let one edge pass, then check the registered result.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic [3:0] es, input logic ec,
                        input logic eo, input string tag);
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.Cin = ci;
        @(posedge clk);
        #1;
        total++;
        assert (bus.S === es) else begin
            bad++;
            $error("FAIL %s.S observed=%0d expected=%0d (A=%0d B=%0d Cin=%0b ovf_exp=%0b)",
                   tag, bus.S, es, a, b, ci, eo);
        end
        total++;
        assert (bus.Cout === ec) else begin
            bad++;
            $error("FAIL %s.Cout observed=%0b expected=%0b", tag, bus.Cout, ec);
        end
`ifdef FOURBIT_ADDER_OVF_EN
        total++;
        assert (bus.Ovf === eo) else begin
            bad++;
            $error("FAIL %s.Ovf observed=%0b expected=%0b", tag, bus.Ovf, eo);
        end
`endif
    endtask

    initial begin
        logic [4:0] ref_sum;
        logic [3:0] av;
        logic [3:0] bv;
        logic       ref_ovf;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        bus.A   = 4'hF;
        bus.B   = 4'hF;
        bus.Cin = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 4'hF, 4'hF, 1'b1, 4'd0, 1'b0, 1'b0, "reset0");
        step(1'b1, 4'hF, 4'hF, 1'b1, 4'd0, 1'b0, 1'b0, "reset1");

        // Back-to-back basic sums, carry-in, wrap and overflow cases.
        step(1'b0, 4'd1,  4'd5,  1'b0, 4'd6,  1'b0, 1'b0, "1+5");
        step(1'b0, 4'd6,  4'd9,  1'b0, 4'd15, 1'b0, 1'b0, "6+9");
        step(1'b0, 4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0, "3+2");
        step(1'b0, 4'd5,  4'd5,  1'b0, 4'd10, 1'b0, 1'b1, "5+5");
        step(1'b0, 4'd4,  4'd5,  1'b1, 4'd10, 1'b0, 1'b1, "4+5+1");
        step(1'b0, 4'd3,  4'd3,  1'b1, 4'd7,  1'b0, 1'b0, "3+3+1");
        step(1'b0, 4'd2,  4'd2,  1'b1, 4'd5,  1'b0, 1'b0, "2+2+1");
        step(1'b0, 4'd11, 4'd2,  1'b1, 4'd14, 1'b0, 1'b0, "11+2+1");
        step(1'b0, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "15+15+1");
        step(1'b0, 4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, "8+8");
        step(1'b0, 4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, "7+1");

        // Reset in the middle of a stream, then immediate resumption.
        step(1'b0, 4'd9,  4'd9,  1'b0, 4'd2,  1'b1, 1'b1, "pre_rst");
        step(1'b1, 4'd9,  4'd9,  1'b0, 4'd0,  1'b0, 1'b0, "mid_rst");
        step(1'b0, 4'd3,  4'd4,  1'b1, 4'd8,  1'b0, 1'b1, "post_rst");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    av      = 4'(a);
                    bv      = 4'(b);
                    ref_sum = 5'(a + b + ci);
                    ref_ovf = (av[3] == bv[3]) && (ref_sum[3] != av[3]);
                    step(1'b0, av, bv, ci[0], ref_sum[3:0], ref_sum[4], ref_ovf,
                         "exhaustive");
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
